// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared types and helpers for the spiking-network readout blocks.
//   decoder_state_t : state encoding of the spike-rate decoder FSM
//   idx_width(n)    : width of an index into n channels, never below 1
// ---------------------------------------------------------------------------
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } decoder_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder_if
// Bundles the spike inputs, the window request and the result handshake of
// the spike-rate decoder.
//   slave  : the decoder side (takes spikes/start/window/ready, drives result)
//   master : the controller/consumer side
// Signals:
//   spike_in[N_OUTPUT]    per-neuron spike pulses from the network
//   start, window_len     window request, window length in cycles
//   busy                  decoder counting or scanning
//   result_valid/ready    result handshake
//   winner_idx/count, tie classification result
//   spike_count[N_OUTPUT] per-channel spike counts
// ---------------------------------------------------------------------------
interface spike_rate_decoder_if #(
  parameter int N_OUTPUT  = 3,
  parameter int CNT_WIDTH = 16,
  parameter int WIN_WIDTH = 16
);
  import snn_pkg::*;

  localparam int IDX_W = idx_width(N_OUTPUT);

  logic                 spike_in     [N_OUTPUT];
  logic                 start;
  logic [WIN_WIDTH-1:0] window_len;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic [IDX_W-1:0]     winner_idx;
  logic [CNT_WIDTH-1:0] winner_count;
  logic                 tie;
  logic [CNT_WIDTH-1:0] spike_count  [N_OUTPUT];

  modport slave (
    input  spike_in, start, window_len, result_ready,
    output busy, result_valid, winner_idx, winner_count, tie, spike_count
  );

  modport master (
    output spike_in, start, window_len, result_ready,
    input  busy, result_valid, winner_idx, winner_count, tie, spike_count
  );

endinterface

// File: rtl/spike_counter_sat.sv
// ---------------------------------------------------------------------------
// spike_counter_sat
// Per-channel saturating up-counter. Clear has priority over enable; once the
// count reaches all-ones it holds there instead of wrapping.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : zero the count
//   en_i     : count one event this cycle
//   cnt_o    : current count
// ---------------------------------------------------------------------------
module spike_counter_sat #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
// Counts spikes per output neuron over a programmable window, then picks the
// neuron with the highest count by scanning one channel per cycle, and offers
// the winner on a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, wins in every state
//   bus  : spike_rate_decoder_if.slave (spikes, window request, result)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; previous result and counts still readable
// COUNT  | sampling spike_in for window_len edges
// ARGMAX | scanning channels 0..N_OUTPUT-1, one per edge
// DONE   | result_valid high, result held until result_ready
// ---------------------------------------------------------------------------
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_OUTPUT  = 3,
  parameter int CNT_WIDTH = 16,
  parameter int WIN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  spike_rate_decoder_if.slave   bus
);

  localparam int IDX_W = idx_width(N_OUTPUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUTPUT - 1);

  decoder_state_t       state_q;
  logic [WIN_WIDTH-1:0] rem_q;
  logic [IDX_W-1:0]     scan_q;
  logic [IDX_W-1:0]     best_idx_q;
  logic [CNT_WIDTH-1:0] best_cnt_q;
  logic                 tie_q;
  logic                 busy_q;
  logic                 valid_q;

  logic [CNT_WIDTH-1:0] cnt [N_OUTPUT];
  logic [CNT_WIDTH-1:0] scan_cnt;
  logic                 clr_cnt;

  // Counts are cleared by the accepted start so the window begins from zero.
  assign clr_cnt = (state_q == IDLE) && bus.start;

  for (genvar g = 0; g < N_OUTPUT; g++) begin : g_chan
    spike_counter_sat #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr_cnt),
      .en_i  ((state_q == COUNT) && bus.spike_in[g]),
      .cnt_o (cnt[g])
    );
    assign bus.spike_count[g] = cnt[g];
  end

  // Mux of the channel under scan; written as a compare loop so index values
  // beyond N_OUTPUT-1 (non power-of-two channel counts) select nothing.
  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N_OUTPUT; i++) begin
      if (scan_q == IDX_W'(i)) begin
        scan_cnt = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      tie_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rem_q      <= bus.window_len;
            scan_q     <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.window_len == '0) begin
              state_q <= ARGMAX;
            end else begin
              state_q <= COUNT;
            end
          end
        end

        COUNT: begin
          // The edge that sees rem_q==1 is the last sampled edge of the window.
          rem_q <= rem_q - 1'b1;
          if (rem_q == WIN_WIDTH'(1)) begin
            state_q <= ARGMAX;
          end
        end

        ARGMAX: begin
          if (scan_q == '0) begin
            best_idx_q <= '0;
            best_cnt_q <= scan_cnt;
            tie_q      <= 1'b0;
          end else if (scan_cnt > best_cnt_q) begin
            best_idx_q <= scan_q;
            best_cnt_q <= scan_cnt;
            tie_q      <= 1'b0;
          end else if (scan_cnt == best_cnt_q) begin
            // Lower index already holds the best; only flag the tie.
            tie_q <= 1'b1;
          end

          if (scan_q == LAST_IDX) begin
            scan_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end

        DONE: begin
          if (bus.result_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.winner_idx   = best_idx_q;
  assign bus.winner_count = best_cnt_q;
  assign bus.tie          = tie_q;

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Sits downstream of spiking_neural_network and is the reader for its spike_L2 output bus. Over a programmable window it counts the spikes on each output neuron, then finds the neuron with the highest count with a sequential argmax. It presents the winning class through a valid/ready handshake. It turns the network's spike trains into a classification result.

Parameters:
N_OUTPUT, 3, number of spike channels; matches the network's N_OUTPUT.
CNT_WIDTH, 16, width of each per-channel spike counter; counters saturate.
WIN_WIDTH, 16, width of the window-length input.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
spike_in  input  1 x [N_OUTPUT] (unpacked, same shape as spike_L2)  per-neuron spike pulses.
start  input  1  request a new counting window; sampled only in IDLE.
window_len  input  WIN_WIDTH  window length in cycles; sampled with start.
busy  output  1  high in COUNT and ARGMAX.
result_valid  output  1  high in DONE.
result_ready  input  1  consumer accepts the result.
winner_idx  output  IDX_W = max(1,$clog2(N_OUTPUT))  index of the highest count.
winner_count  output  CNT_WIDTH  count of the winner.
tie  output  1  another channel equals winner_count.
spike_count  output  CNT_WIDTH x [N_OUTPUT] (unpacked)  per-channel counts.

Behaviour:
- Reset:
  - Synchronous and active-high; it takes priority in any state.
  - State goes to IDLE and all counters to 0.
  - busy=0, result_valid=0, winner_idx=0, winner_count=0, tie=0.
  - Asserting reset mid-window or in DONE aborts the operation and discards any partial result.
- FSM states are IDLE, COUNT, ARGMAX and DONE.
- IDLE:
  - On an edge with start=1, the block latches window_len into the remaining-cycle counter and clears all spike counts.
  - If window_len is nonzero, it moves to COUNT. If window_len is 0, it moves to ARGMAX; all counts are then 0, so the result is winner 0 and tie = (N_OUTPUT>1).
- COUNT:
  - At each edge, every channel i with spike_in[i]=1 increments count[i].
  - Counters saturate at 2^CNT_WIDTH-1; there is no wrap.
  - The remaining-cycle counter decrements at each edge. When it reaches 1, the block moves to ARGMAX.
  - Exactly window_len edges are sampled: if start is accepted at edge t, spikes are sampled at edges t+1 through t+W.
- ARGMAX:
  - Scans one channel per edge, over N_OUTPUT edges.
  - Initial best is idx=0, cnt=count[0], tie=0.
  - For k≥1, the rules are:
    - count[k] > best: update the best and clear tie.
    - count[k] == best: set tie and keep the lower index.
  - After the last channel, the block moves to DONE.
- DONE:
  - result_valid=1. winner_idx, winner_count, tie and spike_count are held stable.
  - When result_ready=1 at an edge, the block moves to IDLE and result_valid drops on the next cycle. It is legal for result_ready to be already high on entry.
- Latency: result_valid asserts after edge t+W+N_OUTPUT, where t is the start edge.
- start is ignored in COUNT, ARGMAX and DONE; it is not queued.
- Changes to window_len after start is accepted have no effect.
- spike_count is driven continuously from the counters. It is only guaranteed meaningful while result_valid=1.
- Results and counts remain readable in IDLE until the next start clears them.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum typedef decoder_state_t (IDLE/COUNT/ARGMAX/DONE);
  - the helper function idx_width(n) returning max(1,$clog2(n)).
- One natural sub-module is spike_counter_sat: a per-channel saturating counter with clear, enable and CNT_WIDTH parameters. It is instantiated N_OUTPUT times in a generate loop.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-COUNT -> next cycle busy=0, result_valid=0, winner_idx=0, all spike_count=0.
2. window_len=10, spike_in[1]=1 every cycle, others 0, start at edge t -> result_valid after edge t+13; winner_idx=1, winner_count=10, tie=0, spike_count={0,10,0}.
3. window_len=8, channels 0 and 2 spike 4 times each, channel 1 twice -> winner_idx=0, winner_count=4, tie=1.
4. Backpressure: hold result_ready=0 for 5 cycles in DONE and pulse start -> outputs unchanged, no restart; set result_ready=1 -> IDLE next cycle, result_valid=0.
5. Saturation with CNT_WIDTH=4: window_len=20, all channels spike every cycle -> all counts=15, winner_idx=0, tie=1.
6. window_len=0 -> result_valid after N_OUTPUT+0 cycles (3), winner_count=0, tie=1; spikes during that time are ignored.
